y86_writeback: RTL

Write-back stage and architectural register file for the Y86-64 SEQ processor. It takes a completed instruction's icode, register specifiers, condition flag and the valE/valM results over a valid/ready handshake, then commits them to a 15-entry 64-bit register file. The register file has one write port, so an instruction with two destinations (popq) commits over two cycles. Two combinational read ports serve the decode stage.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/y86_writeback_if.sv | 17 +
 rtl/y86_regfile.sv | 42 ++++
 rtl/y86_writeback.sv | 137 +++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and
// the write-back FSM state type.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam int         NUM_REGS = 15;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WR_E = 2'd1,
        WB_WR_M = 2'd2,
        WB_DONE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/y86_writeback_if.sv
// Instruction-result handshake between the memory stage (master) and the
// write-back stage (slave).
interface y86_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;

    modport master (output in_valid, icode, rA, rB, cnd, valE, valM,
                    input  in_ready);
    modport slave  (input  in_valid, icode, rA, rB, cnd, valE, valM,
                    output in_ready);
endinterface

// File: rtl/y86_regfile.sv
// Y86-64 architectural register file: 15 x 64-bit, one synchronous write
// port, two combinational read ports; specifier 4'hF reads as zero.
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [63:0] rdata_a,
    output logic [63:0] rdata_b
);

    logic [63:0] mem_q [NUM_REGS];
    logic [63:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && waddr != REG_NONE) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the architecture defines every register as zero after reset, so
    // this array is reset explicitly instead of being left to a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = (raddr_a == REG_NONE) ? 64'd0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == REG_NONE) ? 64'd0 : mem_q[raddr_b];

endmodule

// File: rtl/y86_writeback.sv
// Y86-64 SEQ write-back stage: decodes destinations and commits valE/valM over
// one or two cycles. Define WB_BYPASS_EN to forward the in-flight write to the reads.
module y86_writeback
    import y86_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    y86_writeback_if.slave         bus,
    input  logic [3:0]             srcA,
    input  logic [3:0]             srcB,
    output logic [63:0]            valA,
    output logic [63:0]            valB,
    output logic                   wr_en,
    output logic [3:0]             wr_dst,
    output logic [63:0]            wr_data,
    output logic                   instr_done
);

    wb_state_t   state_q, state_d;
    logic [3:0]  dst_e_q, dst_e_d;
    logic [3:0]  dst_m_q, dst_m_d;
    logic [63:0] val_e_q, val_e_d;
    logic [63:0] val_m_q, val_m_d;
    logic [3:0]  dec_e, dec_m;
    logic        in_ready;
    logic [63:0] rd_a, rd_b;

    always_comb begin
        dec_e = REG_NONE;
        dec_m = REG_NONE;
        case (bus.icode)
            ICODE_CMOVXX:                    if (bus.cnd) dec_e = bus.rB;
            ICODE_IRMOVQ, ICODE_OPQ:         dec_e = bus.rB;
            ICODE_CALL, ICODE_RET,
            ICODE_PUSHQ:                     dec_e = REG_RSP;
            ICODE_POPQ: begin
                dec_e = REG_RSP;
                dec_m = bus.rA;
            end
            ICODE_MRMOVQ:                    dec_m = bus.rA;
            default:                         ;
        endcase
    end

    // NOTE: every output of this block is given a default before the case so
    // that no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        dst_e_d    = dst_e_q;
        dst_m_d    = dst_m_q;
        val_e_d    = val_e_q;
        val_m_d    = val_m_q;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        wr_dst     = REG_NONE;
        wr_data    = 64'd0;
        instr_done = 1'b0;

        case (state_q)
            WB_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    dst_e_d = dec_e;
                    dst_m_d = dec_m;
                    val_e_d = bus.valE;
                    val_m_d = bus.valM;
                    if (dec_e != REG_NONE)      state_d = WB_WR_E;
                    else if (dec_m != REG_NONE) state_d = WB_WR_M;
                    else                        state_d = WB_DONE;
                end
            end
            WB_WR_E: begin
                wr_en   = 1'b1;
                wr_dst  = dst_e_q;
                wr_data = val_e_q;
                state_d = (dst_m_q != REG_NONE) ? WB_WR_M : WB_DONE;
            end
            WB_WR_M: begin
                wr_en   = 1'b1;
                wr_dst  = dst_m_q;
                wr_data = val_m_q;
                state_d = WB_DONE;
            end
            WB_DONE: begin
                instr_done = 1'b1;
                state_d    = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    assign bus.in_ready = in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WB_IDLE;
            dst_e_q <= REG_NONE;
            dst_m_q <= REG_NONE;
            val_e_q <= '0;
            val_m_q <= '0;
        end else begin
            state_q <= state_d;
            dst_e_q <= dst_e_d;
            dst_m_q <= dst_m_d;
            val_e_q <= val_e_d;
            val_m_q <= val_m_d;
        end
    end

    y86_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .waddr   (wr_dst),
        .wdata   (wr_data),
        .raddr_a (srcA),
        .raddr_b (srcB),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to a matching read.
    always_comb begin
        valA = rd_a;
        valB = rd_b;
        if (wr_en && wr_dst != REG_NONE && srcA == wr_dst) valA = wr_data;
        if (wr_en && wr_dst != REG_NONE && srcB == wr_dst) valB = wr_data;
    end
`else
    assign valA = rd_a;
    assign valB = rd_b;
`endif

endmodule
